// File: rtl/hello_msg_streamer_if.sv
// Byte-stream handshake bundle between the message streamer and its consumer.
// The master drives data/valid/last; the slave answers with ready.
interface hello_msg_streamer_if;
    logic [7:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    modport master (
        output data,
        output valid,
        output last,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        input  last,
        output ready
    );
endinterface

// File: rtl/hello_msg_streamer.sv
// Streams "Hello World" REPEAT times on a valid/ready bus, GAP_CYCLES idle between.
// Define HELLO_MSG_CRLF_EN to append CR LF (13-byte message, last on LF).
module hello_msg_streamer #(
    parameter int REPEAT     = 3,
    parameter int GAP_CYCLES = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    hello_msg_streamer_if.master        bus,
    output logic                        busy,
    output logic                        done,
    output logic [7:0]                  msg_cnt
);

`ifdef HELLO_MSG_CRLF_EN
    localparam int LEN = 13;
`else
    localparam int LEN = 11;
`endif

    localparam logic [3:0] LAST_IDX = 4'(LEN - 1);
    localparam logic [7:0] REP8     = 8'(REPEAT);
    localparam logic [7:0] GAP8     = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] msg_cnt_q, msg_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       accept;
    logic [7:0] msg_inc;
    logic [3:0] idx_nxt;

    function automatic logic [7:0] msg_byte(input logic [3:0] i);
        logic [7:0] b;
        case (i)
            4'd0:    b = 8'h48;
            4'd1:    b = 8'h65;
            4'd2:    b = 8'h6C;
            4'd3:    b = 8'h6C;
            4'd4:    b = 8'h6F;
            4'd5:    b = 8'h20;
            4'd6:    b = 8'h57;
            4'd7:    b = 8'h6F;
            4'd8:    b = 8'h72;
            4'd9:    b = 8'h6C;
            4'd10:   b = 8'h64;
            4'd11:   b = 8'h0D;
            4'd12:   b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    assign accept  = valid_q && bus.ready;
    assign msg_inc = msg_cnt_q + 8'd1;
    assign idx_nxt = idx_q + 4'd1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        msg_cnt_d = msg_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEND;
                    idx_d     = 4'd0;
                    msg_cnt_d = 8'd0;
                    data_d    = msg_byte(4'd0);
                    valid_d   = 1'b1;
                    last_d    = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            SEND: begin
                if (accept) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d  = idx_nxt;
                        data_d = msg_byte(idx_nxt);
                        last_d = (idx_nxt == LAST_IDX);
                    end else begin
                        msg_cnt_d = msg_inc;
                        idx_d     = 4'd0;
                        last_d    = 1'b0;
                        // REPEAT of zero means stream until reset
                        if (REPEAT != 0 && msg_inc == REP8) begin
                            state_d = DONE;
                            valid_d = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (GAP_CYCLES != 0) begin
                            state_d = GAP;
                            gap_d   = 8'd0;
                            valid_d = 1'b0;
                        end else begin
                            data_d = msg_byte(4'd0);
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP8 - 8'd1) begin
                    state_d = SEND;
                    idx_d   = 4'd0;
                    data_d  = msg_byte(4'd0);
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            gap_q     <= 8'd0;
            msg_cnt_q <= 8'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            msg_cnt_q <= msg_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.data  = data_q;
    assign bus.valid = valid_q;
    assign bus.last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign msg_cnt   = msg_cnt_q;

endmodule

// File: tb/tb_hello_msg_streamer.sv
// Directed bench for hello_msg_streamer: three instances cover REPEAT=1,
// REPEAT=2 with a gap, and endless back-to-back streaming.
module tb_hello_msg_streamer;

`ifdef HELLO_MSG_CRLF_EN
    localparam int LEN = 13;
`else
    localparam int LEN = 11;
`endif

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic [7:0] cnt_a, cnt_b, cnt_c;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_msg [13] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                                 8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64,
                                 8'h0D, 8'h0A};

    hello_msg_streamer_if ifa ();
    hello_msg_streamer_if ifb ();
    hello_msg_streamer_if ifc ();

    hello_msg_streamer #(.REPEAT(1), .GAP_CYCLES(2)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a), .bus(ifa),
        .busy(busy_a), .done(done_a), .msg_cnt(cnt_a)
    );

    hello_msg_streamer #(.REPEAT(2), .GAP_CYCLES(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b), .bus(ifb),
        .busy(busy_b), .done(done_b), .msg_cnt(cnt_b)
    );

    hello_msg_streamer #(.REPEAT(0), .GAP_CYCLES(0)) dut_c (
        .clock(clock), .reset_n(reset_n), .start(start_c), .bus(ifc),
        .busy(busy_c), .done(done_c), .msg_cnt(cnt_c)
    );

    always #5 clock = ~clock;

    // {valid, last, busy, done, data, msg_cnt}
    wire [19:0] obs_a = {ifa.valid, ifa.last, busy_a, done_a, ifa.data, cnt_a};
    wire [19:0] obs_b = {ifb.valid, ifb.last, busy_b, done_b, ifb.data, cnt_b};
    wire [19:0] obs_c = {ifc.valid, ifc.last, busy_c, done_c, ifc.data, cnt_c};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        ifa.ready = 1'b1;
        ifb.ready = 1'b1;
        ifc.ready = 1'b1;
        reset_n = 1'b0;
        start_a = 1'b1;
        tick();
        tick();
        checks++;
        if (obs_a !== 20'h0) begin
            errors++;
            $display("FAIL reset_a got %h want %h", obs_a, 20'h0);
        end
        checks++;
        if ({obs_b, obs_c} !== 40'h0) begin
            errors++;
            $display("FAIL reset_bc got %h want %h", {obs_b, obs_c}, 40'h0);
        end
        start_a = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_a !== 20'h0) begin
                errors++;
                $display("FAIL idle_no_start got %h want %h", obs_a, 20'h0);
            end
        end
    endtask

    task automatic test_single();
        logic [19:0] exp;
        ifa.ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            exp = {1'b1, 1'(i == LEN - 1), 1'b1, 1'b0, exp_msg[i], 8'd0};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL single_byte%0d got %h want %h", i, obs_a, exp);
            end
            tick();
        end
        exp = {4'b0001, exp_msg[LEN - 1], 8'd1};
        checks++;
        if (obs_a !== exp) begin
            errors++;
            $display("FAIL single_done got %h want %h", obs_a, exp);
        end
        tick();
        exp = {4'b0000, exp_msg[LEN - 1], 8'd1};
        checks++;
        if (obs_a !== exp) begin
            errors++;
            $display("FAIL single_after got %h want %h", obs_a, exp);
        end
    endtask

    task automatic test_gap();
        logic [19:0] exp;
        ifb.ready = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < LEN; i++) begin
                exp = {1'b1, 1'(i == LEN - 1), 1'b1, 1'b0, exp_msg[i], 8'(m)};
                checks++;
                if (obs_b !== exp) begin
                    errors++;
                    $display("FAIL gap_m%0d_b%0d got %h want %h", m, i, obs_b, exp);
                end
                start_b = (m == 0 && i == 5);
                tick();
                start_b = 1'b0;
            end
            if (m == 0) begin
                for (int g = 0; g < 2; g++) begin
                    checks++;
                    if ({ifb.valid, busy_b, done_b, cnt_b} !== {3'b010, 8'd1}) begin
                        errors++;
                        $display("FAIL gap_idle%0d got %h want %h", g,
                                 {ifb.valid, busy_b, done_b, cnt_b}, {3'b010, 8'd1});
                    end
                    tick();
                end
            end
        end
        checks++;
        if ({ifb.valid, busy_b, done_b, cnt_b} !== {3'b001, 8'd2}) begin
            errors++;
            $display("FAIL gap_done got %h want %h",
                     {ifb.valid, busy_b, done_b, cnt_b}, {3'b001, 8'd2});
        end
        // start during the done cycle must not launch a new run
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        tick();
        checks++;
        if ({ifb.valid, busy_b, done_b, cnt_b} !== {3'b000, 8'd2}) begin
            errors++;
            $display("FAIL gap_start_in_done got %h want %h",
                     {ifb.valid, busy_b, done_b, cnt_b}, {3'b000, 8'd2});
        end
    endtask

    task automatic test_stall();
        logic [19:0] exp;
        ifa.ready = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 0; c < 2 * LEN; c++) begin
            exp = {1'b1, 1'(c / 2 == LEN - 1), 1'b1, 1'b0, exp_msg[c / 2], 8'd0};
            checks++;
            if (obs_a !== exp) begin
                errors++;
                $display("FAIL stall_c%0d got %h want %h", c, obs_a, exp);
            end
            ifa.ready = 1'(c % 2);
            tick();
        end
        ifa.ready = 1'b1;
        checks++;
        if ({ifa.valid, busy_a, done_a, cnt_a} !== {3'b001, 8'd1}) begin
            errors++;
            $display("FAIL stall_done got %h want %h",
                     {ifa.valid, busy_a, done_a, cnt_a}, {3'b001, 8'd1});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        ifa.ready = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (ifa.data !== 8'h6F) begin
            errors++;
            $display("FAIL mid_pre got %h want %h", ifa.data, 8'h6F);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (obs_a !== 20'h0) begin
            errors++;
            $display("FAIL mid_reset got %h want %h", obs_a, 20'h0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ifa.valid, done_a} !== 2'b00) begin
                errors++;
                $display("FAIL mid_no_done got %b want %b", {ifa.valid, done_a}, 2'b00);
            end
        end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        checks++;
        if (obs_a !== {4'b1010, 8'h48, 8'd0}) begin
            errors++;
            $display("FAIL mid_replay got %h want %h", obs_a, {4'b1010, 8'h48, 8'd0});
        end
        for (int i = 0; i < LEN; i++) tick();
        checks++;
        if ({done_a, cnt_a} !== {1'b1, 8'd1}) begin
            errors++;
            $display("FAIL mid_replay_done got %h want %h", {done_a, cnt_a}, {1'b1, 8'd1});
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        ifc.ready = 1'b1;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < LEN; i++) begin
                exp = {1'b1, 1'(i == LEN - 1), 1'b1, 1'b0, exp_msg[i], 8'(m)};
                checks++;
                if (obs_c !== exp) begin
                    errors++;
                    $display("FAIL b2b_m%0d_b%0d got %h want %h", m, i, obs_c, exp);
                end
                tick();
            end
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (obs_c !== 20'h0) begin
            errors++;
            $display("FAIL b2b_reset got %h want %h", obs_c, 20'h0);
        end
    endtask

    initial begin
        ifa.ready = 1'b0;
        ifb.ready = 1'b0;
        ifc.ready = 1'b0;
        test_reset();
        test_single();
        test_gap();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
